// File: rtl/cassette_pkg.sv
// Shared definitions for the cassette receive path: framing FSM states and
// default 16 MHz thresholds that match the 1200/2400 Hz playback timing.
package cassette_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int DEF_CLK_HZ         = 16_000_000;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_MIN_CYC        = 3333;
  localparam int DEF_SPLIT          = 10000;
  localparam int DEF_TIMEOUT        = 20000;
  localparam int DEF_CARRIER_CYCLES = 16;

endpackage

// File: rtl/cassette_cycle_classifier.sv
// Synchronises the tape signal, times rising-edge to rising-edge periods and
// emits one-cycle short / long / carrier-timeout pulses.
module cassette_cycle_classifier #(
  parameter int CNT_W   = 16,
  parameter int MIN_CYC = 3333,
  parameter int SPLIT   = 10000,
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_tape,
  output logic o_cyc_s,
  output logic o_cyc_l,
  output logic o_cyc_timeout
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] SPL_C = CNT_W'(SPLIT);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cyc_s, r_cyc_l, r_cyc_to;
  logic             w_rise, w_cls, w_s, w_l, w_to;

  assign w_rise = r_sync2 & ~r_prev;
  // Glitch edges leave the counter running so the real period is still measured.
  assign w_cls  = i_en & w_rise & (r_cnt >= MIN_C);
  assign w_s    = w_cls & (r_cnt < SPL_C);
  assign w_l    = w_cls & (r_cnt >= SPL_C) & (r_cnt < TO_C);
  // An edge after saturation reports timeout rather than long.
  assign w_to   = i_en & (w_rise ? (r_cnt == TO_C) : (r_cnt == TO_M1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1  <= i_tape;
      r_sync2  <= i_tape;
      r_prev   <= i_tape;
      r_cnt    <= '0;
      r_cyc_s  <= 1'b0;
      r_cyc_l  <= 1'b0;
      r_cyc_to <= 1'b0;
    end else begin
      r_sync1  <= i_tape;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_cyc_s  <= w_s;
      r_cyc_l  <= w_l;
      r_cyc_to <= w_to;
      if (!i_en || w_cls) begin
        r_cnt <= '0;
      end else if (r_cnt != TO_C) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cyc_s       = r_cyc_s;
  assign o_cyc_l       = r_cyc_l;
  assign o_cyc_timeout = r_cyc_to;

endmodule

// File: rtl/cassette_decoder.sv
// Electron cassette receiver: carrier acquisition, Acorn byte deframing
// (start 0, 8 data LSB first, stop 1) and a valid/ack byte holding register.
module cassette_decoder
  import cassette_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int MIN_CYC        = DEF_MIN_CYC,
  parameter int SPLIT          = DEF_SPLIT,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int CARRIER_CYCLES = DEF_CARRIER_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       tape_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ack,
  output logic       carrier,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] status
);

  localparam int RUN_W = $clog2(CARRIER_CYCLES + 1);

  if (CLK_HZ <= 0 || TIMEOUT >= (1 << CNT_W) || SPLIT >= TIMEOUT) begin : g_bad_cfg
    $error("cassette_decoder: inconsistent timing parameters");
  end

  logic w_s, w_l, w_to;

  cassette_cycle_classifier #(
    .CNT_W   (CNT_W),
    .MIN_CYC (MIN_CYC),
    .SPLIT   (SPLIT),
    .TIMEOUT (TIMEOUT)
  ) u_cls (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_en          (en),
    .i_tape        (tape_in),
    .o_cyc_s       (w_s),
    .o_cyc_l       (w_l),
    .o_cyc_timeout (w_to)
  );

  state_t           r_state, w_state;
  logic             r_half, w_half;
  logic [2:0]       r_idx, w_idx;
  logic [7:0]       r_shift, w_shift;
  logic [RUN_W-1:0] r_run, w_run;
  logic             w_deliver, w_ferr;
  logic [7:0]       r_data;
  logic             r_valid, r_overrun, r_frame_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_half  <= 1'b0;
      r_idx   <= '0;
      r_shift <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_state;
      r_half  <= w_half;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_run   <= w_run;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_half    = r_half;
    w_idx     = r_idx;
    w_shift   = r_shift;
    w_run     = r_run;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
    if (!en || w_to) begin
      w_state = HUNT;
      w_half  = 1'b0;
      w_idx   = '0;
      w_shift = '0;
      w_run   = '0;
    end else begin
      unique case (r_state)
        HUNT: begin
          if (w_s) begin
            if (r_run == RUN_W'(CARRIER_CYCLES - 1)) begin
              w_state = IDLE;
              w_run   = '0;
            end else begin
              w_run = r_run + 1'b1;
            end
          end else if (w_l) begin
            w_run = '0;
          end
        end
        IDLE: begin
          if (w_l) begin
            w_state = DATA;
            w_idx   = '0;
            w_half  = 1'b0;
          end
        end
        DATA: begin
          // A completed bit is either one L, or two S in a row.
          if ((!r_half && w_l) || (r_half && w_s)) begin
            w_shift = {r_half, r_shift[7:1]};
            w_half  = 1'b0;
            if (r_idx == 3'd7) begin
              w_state = STOP;
            end else begin
              w_idx = r_idx + 1'b1;
            end
          end else if (!r_half && w_s) begin
            w_half = 1'b1;
          end else if (r_half && w_l) begin
            w_ferr  = 1'b1;
            w_state = IDLE;
            w_half  = 1'b0;
            w_shift = '0;
          end
        end
        STOP: begin
          if (w_s) begin
            if (r_half) begin
              w_deliver = 1'b1;
              w_state   = IDLE;
              w_half    = 1'b0;
            end else begin
              w_half = 1'b1;
            end
          end else if (w_l) begin
            w_ferr  = 1'b1;
            w_state = IDLE;
            w_half  = 1'b0;
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_deliver) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid) begin
          r_overrun <= ~byte_ack;
        end
      end else if (r_valid && byte_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign byte_data  = r_data;
  assign byte_valid = r_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;
  assign carrier    = (r_state != HUNT);
  assign status     = r_state;

endmodule
